// File: rtl/flopr_pkg.sv
// Shared constants and helpers for the flopr_pipe pipeline register family.
package flopr_pkg;

  localparam int DEFAULT_N  = 64;
  localparam int MAX_STAGES = 8;

  // Width of an occupancy counter that must count 0..stages inclusive
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/flopr_en_clr.sv
// Single register with synchronous reset, synchronous clear and load enable.
// Reset and clear both force zero; clear wins over enable.
module flopr_en_clr #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Zero on reset/clear, otherwise load when enabled and hold when stalled
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/flopr_pipe.sv
// Multi-stage pipeline register with per-stage valid bits, stall (en) and
// flush. Each stage stores {valid, data}; an empty stage always holds zero
// data, so q reads 0 whenever valid_out is low.
// Optional build macro FLOPR_PIPE_OCC_EN adds an 'occ' output counting the
// number of valid stages.
module flopr_pipe
  import flopr_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int STAGES = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           flush,
  input  logic                           valid_in,
  input  logic [N-1:0]                   d,
  output logic                           valid_out,
`ifdef FLOPR_PIPE_OCC_EN
  output logic [N-1:0]                   q,
  output logic [occ_width(STAGES)-1:0]   occ
`else
  output logic [N-1:0]                   q
`endif
);

  // Reject unsupported configurations at elaboration time
  generate
    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("flopr_pipe: STAGES must be in 1..%0d", MAX_STAGES);
    end
    if (N < 1 || N > 128) begin : g_bad_width
      $error("flopr_pipe: N must be in 1..128");
    end
  endgenerate

  // Per-stage {valid, data} buses; stage 0 is the input end
  logic [N:0] stage_d [STAGES];
  logic [N:0] stage_q [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // Bubbles enter with zero data so empty slots never leak stale values
        assign stage_d[gi] = {valid_in, (valid_in ? d : {N{1'b0}})};
      end else begin : g_body
        assign stage_d[gi] = stage_q[gi-1];
      end

      flopr_en_clr #(
        .W(N + 1)
      ) u_reg (
        .clk  (clk),
        .reset(reset),
        .clr  (flush),
        .en   (en),
        .d    (stage_d[gi]),
        .q    (stage_q[gi])
      );
    end
  endgenerate

  assign valid_out = stage_q[STAGES-1][N];
  assign q         = stage_q[STAGES-1][N-1:0];

`ifdef FLOPR_PIPE_OCC_EN
  localparam int OW = occ_width(STAGES);

  // Track valid-stage count: one enters with valid_in, one leaves with valid_out
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ <= '0;
    end else if (en) begin
      occ <= occ + OW'(valid_in) - OW'(valid_out);
    end
  end
`endif

endmodule
